width_conv_fwft_fifo: RTL and testbench

WIDTH_CONV_FWFT_FIFO -- requirements
Module: width_conv_fwft_fifo

---
 rtl/wconv_fifo_pkg.sv | 13 +
 rtl/width_conv_fwft_fifo_if.sv | 40 ++++
 rtl/wconv_fifo_mem.sv | 31 +++
 rtl/width_conv_fwft_fifo.sv | 82 ++++++++
 tb/tb_width_conv_fwft_fifo.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/wconv_fifo_pkg.sv
// Shared defaults and sizing helper for the width-converting FWFT FIFO.
package wconv_fifo_pkg;

    localparam int DEF_OUT_W = 8;
    localparam int DEF_RATIO = 4;
    localparam int DEF_DEPTH = 16;

    // A one-entry FIFO still needs a one-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/width_conv_fwft_fifo_if.sv
// Write/read handshake bundle for width_conv_fwft_fifo.
// Defining WCONV_FIFO_LEVEL_EN adds the level and almost_full status signals.
interface width_conv_fwft_fifo_if
    import wconv_fifo_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int RATIO = DEF_RATIO,
    parameter int DEPTH = DEF_DEPTH
);
    logic                     flush;
    logic                     wr_valid;
    logic [OUT_W*RATIO-1:0]   wr_data;
    logic                     wr_ready;
    logic                     rd_valid;
    logic [OUT_W-1:0]         rd_data;
    logic                     rd_ready;
    logic                     empty;
    logic                     full;
`ifdef WCONV_FIFO_LEVEL_EN
    logic [ptr_w(DEPTH):0]    level;
    logic                     almost_full;
`endif

    modport master (
        output flush, wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, empty, full
`ifdef WCONV_FIFO_LEVEL_EN
        , input level, almost_full
`endif
    );

    modport slave (
        input  flush, wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, empty, full
`ifdef WCONV_FIFO_LEVEL_EN
        , output level, almost_full
`endif
    );

endinterface

// File: rtl/wconv_fifo_mem.sv
// DEPTH x OUT_W storage: one RATIO-lane write port, one asynchronous read port.
module wconv_fifo_mem
    import wconv_fifo_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int RATIO = DEF_RATIO,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [PW-1:0]          i_wr_ptr,
    input  logic [OUT_W*RATIO-1:0] i_wr_data,
    input  logic [PW-1:0]          i_rd_ptr,
    output logic [OUT_W-1:0]       o_rd_data
);

    logic [OUT_W-1:0] r_mem [DEPTH];

    // Lane k lands at wr_ptr+k; the PW-bit sum wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < RATIO; k++) begin
                r_mem[i_wr_ptr + PW'(k)] <= i_wr_data[k*OUT_W +: OUT_W];
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/width_conv_fwft_fifo.sv
// Wide-in / narrow-out first-word-fall-through FIFO.
// Defining WCONV_FIFO_LEVEL_EN exposes level and almost_full.
module width_conv_fwft_fifo
    import wconv_fifo_pkg::*;
#(
    parameter int OUT_W     = DEF_OUT_W,
    parameter int RATIO     = DEF_RATIO,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_LVL = DEPTH - RATIO
) (
    input  logic                    clk,
    input  logic                    rst_n,
    width_conv_fwft_fifo_if.slave   bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    if (!(RATIO == 1 || RATIO == 2 || RATIO == 4 || RATIO == 8)) begin : g_bad_ratio
        $error("RATIO must be 1, 2, 4 or 8");
    end
    if ((DEPTH & (DEPTH - 1)) != 0 || (DEPTH % RATIO) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and a multiple of RATIO");
    end
    if (AFULL_LVL < 0 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("AFULL_LVL must lie in 0..DEPTH");
    end

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_empty;
    logic [OUT_W-1:0] w_rd_word;

    assign w_empty      = (r_count == '0);
    assign bus.empty    = w_empty;
    assign bus.full     = (r_count == CW'(DEPTH));
    // Uses registered count only, so a same-cycle read never opens the write side.
    assign bus.wr_ready = ((CW'(DEPTH) - r_count) >= CW'(RATIO));
    assign bus.rd_valid = !w_empty;
    assign bus.rd_data  = w_empty ? '0 : w_rd_word;

    assign w_wr_en = bus.wr_valid && bus.wr_ready;
    assign w_rd_en = !w_empty && bus.rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(RATIO);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (w_wr_en ? CW'(RATIO) : '0) - (w_rd_en ? CW'(1) : '0);
        end
    end

`ifdef WCONV_FIFO_LEVEL_EN
    assign bus.level       = r_count;
    assign bus.almost_full = (r_count >= CW'(AFULL_LVL));
`endif

    wconv_fifo_mem #(
        .OUT_W (OUT_W),
        .RATIO (RATIO),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_we      (w_wr_en && !bus.flush),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data (bus.wr_data),
        .i_rd_ptr  (r_rd_ptr),
        .o_rd_data (w_rd_word)
    );

endmodule

// File: tb/tb_width_conv_fwft_fifo.sv
// Directed bench for width_conv_fwft_fifo: default 32->8 instance plus a 16->8 wrap instance.
module tb_width_conv_fwft_fifo;
    import wconv_fifo_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    width_conv_fwft_fifo_if #(.OUT_W(8), .RATIO(4), .DEPTH(16)) bus_a ();
    width_conv_fwft_fifo_if #(.OUT_W(8), .RATIO(2), .DEPTH(16)) bus_b ();

    width_conv_fwft_fifo #(.OUT_W(8), .RATIO(4), .DEPTH(16), .AFULL_LVL(12)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    width_conv_fwft_fifo #(.OUT_W(8), .RATIO(2), .DEPTH(16), .AFULL_LVL(14)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [31:0] d);
        bus_a.wr_valid = 1'b1;
        bus_a.wr_data  = d;
        step();
        bus_a.wr_valid = 1'b0;
    endtask

    task automatic a_read(input string tag, input logic [7:0] exp);
        chk(tag, {24'h0, bus_a.rd_data}, {24'h0, exp});
        bus_a.rd_ready = 1'b1;
        step();
        bus_a.rd_ready = 1'b0;
    endtask

    task automatic b_write(input logic [15:0] d);
        bus_b.wr_valid = 1'b1;
        bus_b.wr_data  = d;
        step();
        bus_b.wr_valid = 1'b0;
    endtask

    task automatic b_read(input string tag, input logic [7:0] exp);
        chk(tag, {24'h0, bus_b.rd_data}, {24'h0, exp});
        bus_b.rd_ready = 1'b1;
        step();
        bus_b.rd_ready = 1'b0;
    endtask

    task automatic a_reset_vals(input string tag);
        chk({tag, "_empty"},    bus_a.empty,    1);
        chk({tag, "_full"},     bus_a.full,     0);
        chk({tag, "_rdvalid"},  bus_a.rd_valid, 0);
        chk({tag, "_rddata"},   bus_a.rd_data,  0);
        chk({tag, "_wrready"},  bus_a.wr_ready, 1);
`ifdef WCONV_FIFO_LEVEL_EN
        chk({tag, "_level"},    bus_a.level,       0);
        chk({tag, "_afull"},    bus_a.almost_full, 0);
`endif
    endtask

    initial begin
        bus_a.flush = 0; bus_a.wr_valid = 0; bus_a.wr_data = '0; bus_a.rd_ready = 0;
        bus_b.flush = 0; bus_b.wr_valid = 0; bus_b.wr_data = '0; bus_b.rd_ready = 0;

        // reset state
        #2;
        a_reset_vals("rst");
        chk("rst_b_empty", bus_b.empty, 1);
        #10 rst_n = 1'b1;
        step();

        // single beat, lane order
        a_write(32'h44332211);
        chk("t1_rdvalid", bus_a.rd_valid, 1);
        a_read("t1_rd0", 8'h11);
        a_read("t1_rd1", 8'h22);
        a_read("t1_rd2", 8'h33);
        a_read("t1_rd3", 8'h44);
        chk("t1_empty", bus_a.empty, 1);

        // fill to full, reject extra beat, drain in order
        for (int i = 0; i < 4; i++)
            a_write({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        chk("t2_full", bus_a.full, 1);
        chk("t2_wrready", bus_a.wr_ready, 0);
`ifdef WCONV_FIFO_LEVEL_EN
        chk("t2_level", bus_a.level, 16);
        chk("t2_afull", bus_a.almost_full, 1);
`endif
        a_write(32'hEEEEEEEE);
        chk("t2_full_after_rej", bus_a.full, 1);
        for (int i = 0; i < 16; i++)
            a_read($sformatf("t2_rd%0d", i), 8'(i));
        chk("t2_empty", bus_a.empty, 1);

        // simultaneous read/write around the wr_ready threshold
        for (int i = 0; i < 3; i++)
            a_write({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        chk("t3_wrready12", bus_a.wr_ready, 1);
`ifdef WCONV_FIFO_LEVEL_EN
        chk("t3_afull12", bus_a.almost_full, 1);
`endif
        chk("t3_head0", bus_a.rd_data, 8'h00);
        bus_a.wr_valid = 1; bus_a.wr_data = 32'h0F0E0D0C; bus_a.rd_ready = 1;
        step();
        bus_a.wr_valid = 0; bus_a.rd_ready = 0;
        chk("t3_wrready15", bus_a.wr_ready, 0);
        chk("t3_full15", bus_a.full, 0);
`ifdef WCONV_FIFO_LEVEL_EN
        chk("t3_level15", bus_a.level, 15);
`endif
        chk("t3_head1", bus_a.rd_data, 8'h01);
        bus_a.wr_valid = 1; bus_a.wr_data = 32'hEEEEEEEE; bus_a.rd_ready = 1;
        step();
        bus_a.wr_valid = 0; bus_a.rd_ready = 0;
        chk("t3_wrready14", bus_a.wr_ready, 0);
`ifdef WCONV_FIFO_LEVEL_EN
        chk("t3_level14", bus_a.level, 14);
`endif
        a_read("t3_rd2", 8'h02);
        chk("t3_wrready13", bus_a.wr_ready, 0);
        a_read("t3_rd3", 8'h03);
        chk("t3_wrready12b", bus_a.wr_ready, 1);
        for (int i = 4; i < 16; i++)
            a_read($sformatf("t3_rd%0d", i), 8'(i));
        chk("t3_empty", bus_a.empty, 1);

        // flush beats a concurrent write and read
        a_write(32'h13121110);
        a_write(32'h17161514);
        bus_a.flush = 1; bus_a.wr_valid = 1; bus_a.wr_data = 32'hEEEEEEEE; bus_a.rd_ready = 1;
        step();
        bus_a.flush = 0; bus_a.wr_valid = 0; bus_a.rd_ready = 0;
        chk("t5_empty", bus_a.empty, 1);
        chk("t5_rdvalid", bus_a.rd_valid, 0);
        chk("t5_rddata", bus_a.rd_data, 0);
        chk("t5_wrready", bus_a.wr_ready, 1);
`ifdef WCONV_FIFO_LEVEL_EN
        chk("t5_level", bus_a.level, 0);
`endif
        a_write(32'h24232221);
        a_read("t5_rd0", 8'h21);
        a_read("t5_rd1", 8'h22);
        a_read("t5_rd2", 8'h23);
        a_read("t5_rd3", 8'h24);
        chk("t5_empty_end", bus_a.empty, 1);

        // asynchronous reset mid-stream at count 6
        a_write(32'h53525150);
        a_write(32'h57565554);
        a_read("t6_rd0", 8'h50);
        a_read("t6_rd1", 8'h51);
        #2 rst_n = 1'b0;
        #1 a_reset_vals("t6");
        #2 rst_n = 1'b1;
        step();
        a_write(32'h64636261);
        a_read("t6_post0", 8'h61);
        a_read("t6_post1", 8'h62);
        a_read("t6_post2", 8'h63);
        a_read("t6_post3", 8'h64);
        chk("t6_empty_end", bus_a.empty, 1);

        // 16->8 instance: move pointers to 14, then wrap into entries 14,15,0,1
        for (int i = 0; i < 7; i++)
            b_write({8'(2*i+1), 8'(2*i)});
        for (int i = 0; i < 14; i++)
            b_read($sformatf("t4_pre%0d", i), 8'(i));
        chk("t4_empty_pre", bus_b.empty, 1);
        b_write(16'hBBAA);
        b_write(16'hDDCC);
        b_read("t4_rd0", 8'hAA);
        b_read("t4_rd1", 8'hBB);
        b_read("t4_rd2", 8'hCC);
        b_read("t4_rd3", 8'hDD);
        chk("t4_empty", bus_b.empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
